// File: rtl/spi_pkg.sv
// Shared types and sizes for the SPI memory peripheral.
// State encoding and field widths used by controller and datapath.
package spi_pkg;

  localparam int SPI_DATA_BITS = 8;
  localparam int SPI_ADDR_BITS = 7;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_LOAD,
    READ_SEND,
    WRITE_GET,
    WRITE_STORE,
    BURST_INC,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating SCLK edge counter for the SPI controller.
// Clear wins over increment; count stops at DATA_BITS.
module spi_bit_counter #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = $clog2(DATA_BITS + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == CNT_W'(DATA_BITS));

  always_ff @(posedge clk) begin
    if (!resetN || clr) begin
      count <= '0;
    end else if (inc && !done) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Sequencing FSM for the SPI memory peripheral.
// Define SPI_CONTROLLER_BURST_EN for address auto-increment bursts.
module spi_controller
  import spi_pkg::*;
#(
  parameter int DATA_BITS = SPI_DATA_BITS,
  parameter int ADDR_BITS = SPI_ADDR_BITS
) (
  input  logic clk,
  input  logic resetN,
  input  logic csN,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic rwBit,
  output logic addrWe,
  output logic srWe,
  output logic dmWe,
  output logic misoBufe,
  output logic addrInc
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

`ifdef SPI_CONTROLLER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  spi_state_t state, next_state;

  logic [CNT_W-1:0] count;
  logic cnt_done;
  logic cnt_clr;
  logic cnt_inc;
  logic last;
  logic rw_reg;

  // ADDR_BITS edges already counted means this edge is the final one
  assign last = (count == CNT_W'(ADDR_BITS));

  assign cnt_inc = (state == GET_ADDR && sclkPosEdge)
                || (state == WRITE_GET && sclkPosEdge)
                || (state == READ_SEND && sclkNegEdge);

  assign cnt_clr = cnt_done
                || (state == IDLE)
                || (next_state == IDLE);

  spi_bit_counter #(
    .DATA_BITS(DATA_BITS),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .resetN(resetN),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rw_reg <= 1'b0;
    end else if (state == GOT_ADDR) begin
      rw_reg <= rwBit;
    end
  end

  always_comb begin
    next_state = state;
    if (state != IDLE && csN) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!csN) next_state = GET_ADDR;
        end
        GET_ADDR: begin
          if (sclkPosEdge && last) next_state = GOT_ADDR;
        end
        GOT_ADDR: begin
          next_state = rwBit ? READ_LOAD : WRITE_GET;
        end
        READ_LOAD: begin
          next_state = READ_SEND;
        end
        READ_SEND: begin
          if (sclkNegEdge && last)
            next_state = BURST ? BURST_INC : DONE;
        end
        WRITE_GET: begin
          if (sclkPosEdge && last) next_state = WRITE_STORE;
        end
        WRITE_STORE: begin
          next_state = BURST ? BURST_INC : DONE;
        end
        BURST_INC: begin
          next_state = rw_reg ? READ_LOAD : WRITE_GET;
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered copies of the decode of the next state
  always_ff @(posedge clk) begin
    if (!resetN) begin
      addrWe   <= 1'b0;
      srWe     <= 1'b0;
      dmWe     <= 1'b0;
      misoBufe <= 1'b0;
    end else begin
      addrWe   <= (next_state == GOT_ADDR);
      srWe     <= (next_state == READ_LOAD);
      dmWe     <= (next_state == WRITE_STORE);
      misoBufe <= (next_state == READ_SEND);
    end
  end

`ifdef SPI_CONTROLLER_BURST_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      addrInc <= 1'b0;
    end else begin
      addrInc <= (next_state == BURST_INC);
    end
  end
`else
  assign addrInc = 1'b0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: random SCLK transactions,
// expected strobe events derived from the edge schedule.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic csN = 1'b1;
  logic sclkPosEdge = 1'b0;
  logic sclkNegEdge = 1'b0;
  logic rwBit = 1'b0;
  logic addrWe, srWe, dmWe, misoBufe, addrInc;

  spi_controller dut (
    .clk        (clk),
    .resetN     (resetN),
    .csN        (csN),
    .sclkPosEdge(sclkPosEdge),
    .sclkNegEdge(sclkNegEdge),
    .rwBit      (rwBit),
    .addrWe     (addrWe),
    .srWe       (srWe),
    .dmWe       (dmWe),
    .misoBufe   (misoBufe),
    .addrInc    (addrInc)
  );

  always #5 clk = ~clk;

`ifdef SPI_CONTROLLER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int K_FALL = 0;
  localparam int K_AWE  = 1;
  localparam int K_SRWE = 2;
  localparam int K_DMWE = 3;
  localparam int K_INC  = 4;
  localparam int K_RISE = 5;

  typedef struct {
    int kind;
    int t;
  } ev_t;

  typedef struct {
    int t;
    bit pos;
    bit mosi;
  } edge_t;

  ev_t   exp_q[$];
  edge_t edges[$];

  int tcur   = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic miso_q = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_FALL:  return "misoBufe_fall";
      K_AWE:   return "addrWe";
      K_SRWE:  return "srWe";
      K_DMWE:  return "dmWe";
      K_INC:   return "addrInc";
      K_RISE:  return "misoBufe_rise";
      default: return "none";
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    tcur++;
  endtask

  task automatic see(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s at t=%0d, required none",
               kname(k), tcur);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.t != tcur) begin
        errors++;
        $display("FAIL event: got %s at t=%0d, required %s at t=%0d",
                 kname(k), tcur, kname(e.kind), e.t);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].t < tcur) begin
          checks++;
          errors++;
          $display("FAIL missing: got nothing by t=%0d, required %s at t=%0d",
                   tcur, kname(exp_q[0].kind), exp_q[0].t);
          void'(exp_q.pop_front());
        end
        if (miso_q && !misoBufe) see(K_FALL);
        if (addrWe)  see(K_AWE);
        if (srWe)    see(K_SRWE);
        if (dmWe)    see(K_DMWE);
        if (addrInc) see(K_INC);
        if (!miso_q && misoBufe) see(K_RISE);
        miso_q = misoBufe;
      end
    end
  end

  // Reference: walk the SCLK edge list in time order; a byte completes on
  // its 8th counted edge, and csN high (or reset) at ch cancels later events.
  task automatic plan(input int c0, input int ch, input bit rw);
    ev_t loc[$];
    int phase;
    int cnt;
    int win;
    bit on;
    phase = 0;
    cnt   = 0;
    win   = c0 + 1;
    on    = 1'b0;
    foreach (edges[i]) begin
      if (edges[i].t >= ch) break;
      if (edges[i].t >= win) begin
        case (phase)
          0: if (edges[i].pos) begin
            cnt++;
            if (cnt == 8) begin
              cnt = 0;
              loc.push_back(ev_t'{K_AWE, edges[i].t + 1});
              if (rw) begin
                loc.push_back(ev_t'{K_SRWE, edges[i].t + 2});
                loc.push_back(ev_t'{K_RISE, edges[i].t + 3});
                phase = 1;
                win = edges[i].t + 3;
              end else begin
                phase = 2;
                win = edges[i].t + 2;
              end
            end
          end
          1: if (!edges[i].pos) begin
            cnt++;
            if (cnt == 8) begin
              cnt = 0;
              loc.push_back(ev_t'{K_FALL, edges[i].t + 1});
              if (BURST) begin
                loc.push_back(ev_t'{K_INC, edges[i].t + 1});
                loc.push_back(ev_t'{K_SRWE, edges[i].t + 2});
                loc.push_back(ev_t'{K_RISE, edges[i].t + 3});
                win = edges[i].t + 3;
              end else begin
                phase = 3;
              end
            end
          end
          2: if (edges[i].pos) begin
            cnt++;
            if (cnt == 8) begin
              cnt = 0;
              loc.push_back(ev_t'{K_DMWE, edges[i].t + 1});
              if (BURST) begin
                loc.push_back(ev_t'{K_INC, edges[i].t + 2});
                win = edges[i].t + 3;
              end else begin
                phase = 3;
              end
            end
          end
          default: ;
        endcase
      end
    end
    foreach (loc[i]) begin
      if (loc[i].t <= ch) begin
        exp_q.push_back(loc[i]);
        if (loc[i].kind == K_RISE) on = 1'b1;
        if (loc[i].kind == K_FALL) on = 1'b0;
      end
    end
    if (on) exp_q.push_back(ev_t'{K_FALL, ch + 1});
  endtask

  task automatic idle_check(input string name);
    checks++;
    if ({addrWe, srWe, dmWe, misoBufe, addrInc} !== 5'b0) begin
      errors++;
      $display("FAIL %s: outputs %b, required 00000",
               name, {addrWe, srWe, dmWe, misoBufe, addrInc});
    end
  endtask

  // abort_clk < 0: normal end; else csN (or reset) rises abort_dly
  // cycles after SCLK rising edge number abort_clk
  task automatic run_txn(input logic [7:0] abyte, input int nbytes,
                         input int h, input int abort_clk,
                         input int abort_dly, input bit rst_abort);
    int c0, p0, n, ch, endt, ei;
    logic [7:0] sr;
    c0 = tcur + 1;
    p0 = c0 + 2;
    n  = 8 * (1 + nbytes);
    for (int k = 0; k < n; k++) begin
      edges.push_back(edge_t'{p0 + 2*h*k, 1'b1,
        (k < 8) ? abyte[7-k] : 1'($urandom_range(0, 1))});
      edges.push_back(edge_t'{p0 + 2*h*k + h, 1'b0, 1'b0});
    end
    if (abort_clk >= 0) ch = p0 + 2*h*abort_clk + abort_dly;
    else ch = p0 + 2*h*(n-1) + h + 3;
    plan(c0, ch, abyte[0]);
    endt = ch + 6;
    ei = 0;
    sr = 8'h00;
    for (int u = c0; u <= endt; u++) begin
      step();
      csN = !(u < ch);
      resetN = !(rst_abort && u == ch);
      rwBit = sr[0];
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
      if (ei < edges.size() && edges[ei].t == u) begin
        if (edges[ei].pos) begin
          sclkPosEdge = 1'b1;
          sr = {sr[6:0], edges[ei].mosi};
        end else begin
          sclkNegEdge = 1'b1;
        end
        ei++;
      end
    end
    step();
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    resetN = 1'b1;
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected events unseen, required 0",
               exp_q.size());
      exp_q.delete();
    end
    idle_check("idle_after_txn");
    edges.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int ab;
    resetN = 1'b0;
    repeat (3) step();
    idle_check("reset_state");
    resetN = 1'b1;
    step();
    mon_en = 1'b1;

    // write 0b0000101_0, data byte
    run_txn(8'b0000_1010, 1, 4, -1, 0, 1'b0);
    // read 0b0000101_1
    run_txn(8'b0000_1011, 1, 4, -1, 0, 1'b0);
    // write aborted after 5 data edges
    run_txn(8'b0000_1010, 1, 5, 12, 2, 1'b0);
    // reset mid-read while MISO driven
    run_txn(8'b0000_1011, 1, 5, 9, 2, 1'b1);
    run_txn(8'b0000_1011, 1, 4, -1, 0, 1'b0);

    // strobes with csN high must be ignored
    csN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      sclkPosEdge = 1'b1;
      step();
      sclkPosEdge = 1'b0;
      repeat (3) step();
      idle_check("idle_edges");
    end
    run_txn(8'b0000_1010, 1, 4, -1, 0, 1'b0);

    // held csN across 3 data bytes
    run_txn(8'b0000_1010, 3, 4, -1, 0, 1'b0);
    run_txn(8'b0000_1011, 3, 4, -1, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(1, 3);
      ab = $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 3)
        run_txn(8'(ab), n, $urandom_range(4, 7),
                $urandom_range(0, 8*(1+n) - 1),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else
        run_txn(8'(ab), n, $urandom_range(4, 7), -1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
